// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings for the multicycle ALU sequencer (honours ALU_SEQ_ZERO_BRANCH_EN)
package alu_seq_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMACC = 4'd3,
        S_WB     = 4'd4,
        S_BRANCH = 4'd5,
        S_JUMP   = 4'd6
    } state_t;

    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADDU = 5'd1;
    localparam logic [4:0] ALUOP_ADD  = 5'd2;
    localparam logic [4:0] ALUOP_SUBU = 5'd3;
    localparam logic [4:0] ALUOP_SUB  = 5'd4;
    localparam logic [4:0] ALUOP_AND  = 5'd5;
    localparam logic [4:0] ALUOP_OR   = 5'd6;
    localparam logic [4:0] ALUOP_NOR  = 5'd7;
    localparam logic [4:0] ALUOP_XOR  = 5'd8;
    localparam logic [4:0] ALUOP_SLTU = 5'd9;
    localparam logic [4:0] ALUOP_SLT  = 5'd10;
    localparam logic [4:0] ALUOP_SEQ  = 5'd11;
    localparam logic [4:0] ALUOP_SNE  = 5'd12;
    localparam logic [4:0] ALUOP_LTZ  = 5'd13;
    localparam logic [4:0] ALUOP_GEZ  = 5'd14;
    localparam logic [4:0] ALUOP_LEZ  = 5'd15;
    localparam logic [4:0] ALUOP_GTZ  = 5'd16;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_REGA   = 1'b1;
    localparam logic [1:0] SRCB_REGB   = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

`ifdef ALU_SEQ_ZERO_BRANCH_EN
    localparam logic ZERO_BRANCH_EN = 1'b1;
`else
    localparam logic ZERO_BRANCH_EN = 1'b0;
`endif

endpackage

// File: rtl/alu_seq_funct_dec.sv
// alu_seq_funct_dec: combinational opcode/funct/rt -> ALU code and legality decoder
module alu_seq_funct_dec
    import alu_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output logic [4:0] alu_op,
    output logic       legal
);

    // one code per instruction: EXEC op for R/I-type, compare op for branches
    always_comb begin
        alu_op = ALUOP_NOP;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: alu_op = ALUOP_ADDU;
                    FN_ADD:  alu_op = ALUOP_ADD;
                    FN_SUBU: alu_op = ALUOP_SUBU;
                    FN_SUB:  alu_op = ALUOP_SUB;
                    FN_AND:  alu_op = ALUOP_AND;
                    FN_OR:   alu_op = ALUOP_OR;
                    FN_NOR:  alu_op = ALUOP_NOR;
                    FN_XOR:  alu_op = ALUOP_XOR;
                    FN_SLTU: alu_op = ALUOP_SLTU;
                    FN_SLT:  alu_op = ALUOP_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDIU: alu_op = ALUOP_ADDU;
            OP_ANDI:  alu_op = ALUOP_AND;
            OP_ORI:   alu_op = ALUOP_OR;
            OP_XORI:  alu_op = ALUOP_XOR;
            OP_SLTI:  alu_op = ALUOP_SLT;
            OP_SLTIU: alu_op = ALUOP_SLTU;
            OP_BEQ:   alu_op = ALUOP_SEQ;
            OP_BNE:   alu_op = ALUOP_SNE;
            OP_REGIMM: begin
                alu_op = (rt == RT_BLTZ) ? ALUOP_LTZ : ALUOP_GEZ;
                legal  = ZERO_BRANCH_EN && (rt == RT_BLTZ || rt == RT_BGEZ);
            end
            OP_BLEZ: begin
                alu_op = ALUOP_LEZ;
                legal  = ZERO_BRANCH_EN;
            end
            OP_BGTZ: begin
                alu_op = ALUOP_GTZ;
                legal  = ZERO_BRANCH_EN;
            end
            OP_J, OP_JAL: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multicycle fetch/decode/execute control FSM (zero-compare branches need ALU_SEQ_ZERO_BRANCH_EN)
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       alu_compare,
    input  logic       mem_ready,
    output logic [4:0] alu_ctrl,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q, state_n;
    logic [4:0] dec_op;
    logic       dec_legal;
    logic       is_rtype, is_lw, is_sw, is_jump, is_branch;

    alu_seq_funct_dec u_dec (
        .opcode (opcode),
        .funct  (funct),
        .rt     (rt),
        .alu_op (dec_op),
        .legal  (dec_legal)
    );

    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_REGIMM) ||
                       (opcode == OP_BLEZ) || (opcode == OP_BGTZ);
    assign state     = state_q;

    // state register, reset wins even mid memory wait
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_n;
    end

    // next state and per-state outputs; write strobes are masked while rst is high
    always_comb begin
        state_n    = state_q;
        alu_ctrl   = ALUOP_NOP;
        alu_srca   = SRCA_PC;
        alu_srcb   = SRCB_REGB;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                alu_ctrl = ALUOP_ADDU;
                alu_srcb = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_ctrl = ALUOP_ADDU;
                alu_srcb = SRCB_IMM_SH;
                if (is_rtype) state_n = S_EXEC;
                else if (!dec_legal) begin
                    illegal = 1'b1;
                    state_n = S_FETCH;
                end
                else if (is_jump) state_n = S_JUMP;
                else if (is_branch) state_n = S_BRANCH;
                else state_n = S_EXEC;
            end
            S_EXEC: begin
                alu_srca = SRCA_REGA;
                alu_srcb = is_rtype ? SRCB_REGB : SRCB_IMM;
                alu_ctrl = dec_op;
                if (!dec_legal) begin
                    illegal = 1'b1;
                    state_n = S_FETCH;
                end
                else state_n = (is_lw || is_sw) ? S_MEMACC : S_WB;
            end
            S_MEMACC: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = is_sw;
                if (mem_ready) state_n = is_sw ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype ? REGDST_RD : REGDST_RT;
                mem_to_reg = is_lw;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                alu_srca  = SRCA_REGA;
                alu_srcb  = SRCB_REGB;
                alu_ctrl  = dec_op;
                pc_write  = alu_compare;
                pc_source = alu_compare ? PCSRC_ALUOUT : PCSRC_ALU;
                state_n   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                reg_write = (opcode == OP_JAL);
                reg_dst   = (opcode == OP_JAL) ? REGDST_R31 : REGDST_RT;
                state_n   = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for the multicycle control FSM
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic [4:0] rt = '0;
    logic       alu_compare = 1'b0;
    logic       mem_ready = 1'b0;
    logic [4:0] alu_ctrl;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
        .alu_compare(alu_compare), .mem_ready(mem_ready), .alu_ctrl(alu_ctrl),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .pc_write(pc_write),
        .pc_source(pc_source), .ir_write(ir_write), .mem_req(mem_req),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        vecs++; if (state !== 4'd0) begin errs++; $display("FAIL rst_state got %0d want 0", state); end
        vecs++; if (pc_write !== 1'b0 || ir_write !== 1'b0) begin errs++; $display("FAIL rst_strobes got pc_write=%0b ir_write=%0b want 0", pc_write, ir_write); end
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        vecs++; if (state !== 4'd0 || mem_req !== 1'b1 || iord !== 1'b0) begin errs++; $display("FAIL fetch_req got state=%0d mem_req=%0b iord=%0b want 0/1/0", state, mem_req, iord); end
        vecs++; if (alu_ctrl !== 5'd1 || alu_srca !== 1'b0 || alu_srcb !== 2'd1) begin errs++; $display("FAIL fetch_alu got ctrl=%0d srca=%0b srcb=%0d want 1/0/1", alu_ctrl, alu_srca, alu_srcb); end
        vecs++; if (illegal !== 1'b0 || ir_write !== 1'b0) begin errs++; $display("FAIL fetch_wait got illegal=%0b ir_write=%0b want 0/0", illegal, ir_write); end
        tick();
        vecs++; if (state !== 4'd0) begin errs++; $display("FAIL fetch_hold got %0d want 0", state); end
    endtask

    task automatic test_addu;
        opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1; cyc = 0;
        #1;
        vecs++; if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_source !== 2'd0) begin errs++; $display("FAIL addu_fetch got ir=%0b pc=%0b src=%0d want 1/1/0", ir_write, pc_write, pc_source); end
        tick();
        vecs++; if (state !== 4'd1 || alu_ctrl !== 5'd1 || alu_srcb !== 2'd3) begin errs++; $display("FAIL addu_decode got state=%0d ctrl=%0d srcb=%0d want 1/1/3", state, alu_ctrl, alu_srcb); end
        tick();
        vecs++; if (state !== 4'd2 || alu_ctrl !== 5'd1 || alu_srca !== 1'b1 || alu_srcb !== 2'd0) begin errs++; $display("FAIL addu_exec got state=%0d ctrl=%0d srca=%0b srcb=%0d want 2/1/1/0", state, alu_ctrl, alu_srca, alu_srcb); end
        tick();
        vecs++; if (state !== 4'd4 || reg_write !== 1'b1 || reg_dst !== 2'd1 || mem_to_reg !== 1'b0) begin errs++; $display("FAIL addu_wb got state=%0d rw=%0b dst=%0d m2r=%0b want 4/1/1/0", state, reg_write, reg_dst, mem_to_reg); end
        tick();
        vecs++; if (state !== 4'd0 || cyc !== 4 || reg_write !== 1'b0) begin errs++; $display("FAIL addu_done got state=%0d cycles=%0d rw=%0b want 0/4/0", state, cyc, reg_write); end
    endtask

    task automatic test_rtype_table;
        logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h27, 6'h2A, 6'h3F};
        logic [4:0] op [5] = '{5'd2, 5'd4, 5'd7, 5'd10, 5'd0};
        for (int i = 0; i < 5; i++) begin
            opcode = 6'h00; funct = fn[i]; mem_ready = 1'b1;
            tick();
            tick();
            vecs++; if (state !== 4'd2 || alu_ctrl !== op[i] || illegal !== (i == 4)) begin errs++; $display("FAIL rtype_exec[%0d] got state=%0d ctrl=%0d ill=%0b want 2/%0d/%0b", i, state, alu_ctrl, illegal, op[i], i == 4); end
            tick();
            if (i != 4) tick();
            vecs++; if (state !== 4'd0) begin errs++; $display("FAIL rtype_done[%0d] got %0d want 0", i, state); end
        end
    endtask

    task automatic test_lw;
        opcode = 6'h23; mem_ready = 1'b1; cyc = 0;
        tick();
        tick();
        vecs++; if (state !== 4'd2 || alu_srcb !== 2'd2 || alu_ctrl !== 5'd1) begin errs++; $display("FAIL lw_exec got state=%0d srcb=%0d ctrl=%0d want 2/2/1", state, alu_srcb, alu_ctrl); end
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            vecs++; if (state !== 4'd3 || mem_req !== 1'b1 || iord !== 1'b1 || mem_write !== 1'b0) begin errs++; $display("FAIL lw_mem[%0d] got state=%0d req=%0b iord=%0b wr=%0b want 3/1/1/0", i, state, mem_req, iord, mem_write); end
            tick();
        end
        vecs++; if (state !== 4'd4 || mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 2'd0) begin errs++; $display("FAIL lw_wb got state=%0d m2r=%0b rw=%0b dst=%0d want 4/1/1/0", state, mem_to_reg, reg_write, reg_dst); end
        tick();
        vecs++; if (state !== 4'd0 || cyc !== 7) begin errs++; $display("FAIL lw_done got state=%0d cycles=%0d want 0/7", state, cyc); end
    endtask

    task automatic test_sw;
        opcode = 6'h2B; mem_ready = 1'b1; cyc = 0;
        tick();
        tick();
        tick();
        vecs++; if (state !== 4'd3 || mem_write !== 1'b1 || iord !== 1'b1) begin errs++; $display("FAIL sw_mem got state=%0d wr=%0b iord=%0b want 3/1/1", state, mem_write, iord); end
        tick();
        vecs++; if (state !== 4'd0 || cyc !== 4) begin errs++; $display("FAIL sw_done got state=%0d cycles=%0d want 0/4", state, cyc); end
    endtask

    task automatic test_beq;
        for (int i = 0; i < 2; i++) begin
            opcode = 6'h04; mem_ready = 1'b1; alu_compare = (i == 0); cyc = 0;
            tick();
            tick();
            vecs++; if (state !== 4'd5 || alu_ctrl !== 5'd11 || alu_srca !== 1'b1 || alu_srcb !== 2'd0) begin errs++; $display("FAIL beq_branch[%0d] got state=%0d ctrl=%0d srca=%0b srcb=%0d want 5/11/1/0", i, state, alu_ctrl, alu_srca, alu_srcb); end
            vecs++; if (pc_write !== (i == 0) || (i == 0 && pc_source !== 2'd1)) begin errs++; $display("FAIL beq_pc[%0d] got pc_write=%0b src=%0d want %0b/1", i, pc_write, pc_source, i == 0); end
            tick();
            vecs++; if (state !== 4'd0 || cyc !== 3) begin errs++; $display("FAIL beq_done[%0d] got state=%0d cycles=%0d want 0/3", i, state, cyc); end
        end
        alu_compare = 1'b0;
    endtask

    task automatic test_bgtz;
        opcode = 6'h07; mem_ready = 1'b1;
        tick();
`ifdef ALU_SEQ_ZERO_BRANCH_EN
        vecs++; if (illegal !== 1'b0) begin errs++; $display("FAIL bgtz_decode got illegal=%0b want 0", illegal); end
        tick();
        vecs++; if (state !== 4'd5 || alu_ctrl !== 5'd16) begin errs++; $display("FAIL bgtz_branch got state=%0d ctrl=%0d want 5/16", state, alu_ctrl); end
`else
        vecs++; if (state !== 4'd1 || illegal !== 1'b1) begin errs++; $display("FAIL bgtz_decode got state=%0d illegal=%0b want 1/1", state, illegal); end
`endif
        tick();
        vecs++; if (state !== 4'd0 || illegal !== 1'b0) begin errs++; $display("FAIL bgtz_done got state=%0d illegal=%0b want 0/0", state, illegal); end
    endtask

    task automatic test_jal;
        opcode = 6'h03; mem_ready = 1'b1;
        tick();
        tick();
        vecs++; if (state !== 4'd6 || pc_write !== 1'b1 || pc_source !== 2'd2 || reg_write !== 1'b1 || reg_dst !== 2'd2) begin errs++; $display("FAIL jal_jump got state=%0d pc=%0b src=%0d rw=%0b dst=%0d want 6/1/2/1/2", state, pc_write, pc_source, reg_write, reg_dst); end
        tick();
        vecs++; if (state !== 4'd0) begin errs++; $display("FAIL jal_done got %0d want 0", state); end
    endtask

    task automatic test_reset_memacc;
        opcode = 6'h2B; mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        vecs++; if (state !== 4'd3 || mem_req !== 1'b1 || mem_write !== 1'b1) begin errs++; $display("FAIL rstmem_pre got state=%0d req=%0b wr=%0b want 3/1/1", state, mem_req, mem_write); end
        rst = 1'b1;
        #1;
        vecs++; if (mem_write !== 1'b0 || reg_write !== 1'b0) begin errs++; $display("FAIL rstmem_strobe got wr=%0b rw=%0b want 0/0", mem_write, reg_write); end
        tick();
        rst = 1'b0;
        #1;
        vecs++; if (state !== 4'd0 || mem_req !== 1'b1 || iord !== 1'b0) begin errs++; $display("FAIL rstmem_fetch got state=%0d req=%0b iord=%0b want 0/1/0", state, mem_req, iord); end
    endtask

    task automatic test_illegal;
        opcode = 6'h3F; mem_ready = 1'b1;
        tick();
        vecs++; if (state !== 4'd1 || illegal !== 1'b1 || reg_write !== 1'b0) begin errs++; $display("FAIL ill_decode got state=%0d ill=%0b rw=%0b want 1/1/0", state, illegal, reg_write); end
        mem_ready = 1'b0;
        tick();
        vecs++; if (state !== 4'd0 || illegal !== 1'b0 || reg_write !== 1'b0) begin errs++; $display("FAIL ill_done got state=%0d ill=%0b rw=%0b want 0/0/0", state, illegal, reg_write); end
        tick();
        vecs++; if (state !== 4'd0 || illegal !== 1'b0) begin errs++; $display("FAIL ill_after got state=%0d ill=%0b want 0/0", state, illegal); end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_rtype_table();
        test_lw();
        test_sw();
        test_beq();
        test_bgtz();
        test_jal();
        test_reset_memacc();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
